reg_write_scheduler: RTL and testbench

//   Accepts register writes from two requesters: SPI (port A) and an

---
 rtl/reg_write_scheduler.sv | 132 +++++++++++++
 tb/tb_reg_write_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scheduler.sv
// Two-port register-write scheduler: round-robin accept into a shared FIFO, one write per cycle out.
// Global writes (number[14]=0) only leave the FIFO inside the window opened by i_FrameStart.
module reg_write_scheduler #(
    parameter int DEPTH         = 8,
    parameter int GLOBAL_WINDOW = 4
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_A_Valid,
    output logic                       o_A_Ready,
    input  logic [14:0]                i_A_Number,
    input  logic [15:0]                i_A_Value,
    input  logic                       i_B_Valid,
    output logic                       o_B_Ready,
    input  logic [14:0]                i_B_Number,
    input  logic [15:0]                i_B_Value,
    input  logic                       i_FrameStart,
    output logic                       o_RegisterWriteEnable,
    output logic [14:0]                o_RegisterWriteNumber,
    output logic [15:0]                o_RegisterWriteValue,
    output logic [$clog2(DEPTH+1)-1:0] o_Pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WIN_W = $clog2(GLOBAL_WINDOW + 1);

    // Storage is read asynchronously: the head's number[14] gates the pop in the same cycle.
    logic [14:0] num_mem [DEPTH];
    logic [15:0] val_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             prio_b_reg, prio_b_next;
    logic [WIN_W-1:0] win_reg, win_next;

    logic        full;
    logic        empty;
    logic        a_push;
    logic        b_push;
    logic        push;
    logic [14:0] push_num;
    logic [15:0] push_val;
    logic        win_active;
    logic [14:0] head_num;
    logic [15:0] head_val;
    logic        pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    assign o_A_Ready = !full && (!i_B_Valid || !prio_b_reg);
    assign o_B_Ready = !full && (!i_A_Valid ||  prio_b_reg);
    assign a_push    = i_A_Valid && o_A_Ready;
    assign b_push    = i_B_Valid && o_B_Ready;
    assign push      = a_push || b_push;
    assign push_num  = a_push ? i_A_Number : i_B_Number;
    assign push_val  = a_push ? i_A_Value  : i_B_Value;

    assign win_active = i_FrameStart || (win_reg != '0);
    assign head_num   = num_mem[rd_ptr_reg];
    assign head_val   = val_mem[rd_ptr_reg];
    // A blocked global head stalls everything behind it; strict order is kept on purpose.
    assign pop        = !empty && (head_num[14] || win_active);

    assign o_Pending = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        prio_b_next = prio_b_reg;
        win_next    = win_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // Priority only rotates on genuine contention that resulted in a grant.
        if (i_A_Valid && i_B_Valid && push) begin
            prio_b_next = !prio_b_reg;
        end

        if (i_FrameStart) begin
            win_next = WIN_W'(GLOBAL_WINDOW - 1);
        end else if (win_reg != '0) begin
            win_next = win_reg - WIN_W'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_reg            <= '0;
            rd_ptr_reg            <= '0;
            count_reg             <= '0;
            prio_b_reg            <= 1'b0;
            win_reg               <= '0;
            o_RegisterWriteEnable <= 1'b0;
            o_RegisterWriteNumber <= '0;
            o_RegisterWriteValue  <= '0;
        end else begin
            wr_ptr_reg            <= wr_ptr_next;
            rd_ptr_reg            <= rd_ptr_next;
            count_reg             <= count_next;
            prio_b_reg            <= prio_b_next;
            win_reg               <= win_next;
            o_RegisterWriteEnable <= pop;
            if (pop) begin
                o_RegisterWriteNumber <= head_num;
                o_RegisterWriteValue  <= head_val;
            end
        end
    end

    // Entry contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_Clock) begin
        if (push && !i_Reset) begin
            num_mem[wr_ptr_reg] <= push_num;
            val_mem[wr_ptr_reg] <= push_val;
        end
    end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench for reg_write_scheduler: expected writes (data and issue cycle) go into a
// scoreboard queue; a negedge monitor pops and compares whenever the write strobe is high.
module tb_reg_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [14:0] a_num = '0;
    logic [15:0] a_val = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [14:0] b_num = '0;
    logic [15:0] b_val = '0;
    logic        frame = 1'b0;
    logic        we;
    logic [14:0] wnum;
    logic [15:0] wval;
    logic [3:0]  pending;

    typedef struct {
        logic [14:0] num;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [14:0] qa_num[$];
    logic [15:0] qa_val[$];
    logic [14:0] qb_num[$];
    logic [15:0] qb_val[$];

    int checks = 0;
    int errors = 0;
    int ec = 0;

    reg_write_scheduler #(.DEPTH(8), .GLOBAL_WINDOW(4)) dut (
        .i_Clock              (clk),
        .i_Reset              (rst),
        .i_A_Valid            (a_valid),
        .o_A_Ready            (a_ready),
        .i_A_Number           (a_num),
        .i_A_Value            (a_val),
        .i_B_Valid            (b_valid),
        .o_B_Ready            (b_ready),
        .i_B_Number           (b_num),
        .i_B_Value            (b_val),
        .i_FrameStart         (frame),
        .o_RegisterWriteEnable(we),
        .o_RegisterWriteNumber(wnum),
        .o_RegisterWriteValue (wval),
        .o_Pending            (pending)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            ec++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ec);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, ec);
        end
    endtask

    task automatic expect_write(input logic [14:0] n, input logic [15:0] v, input int c);
        exp_t e;
        e.num = n;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present qa/qb items on both ports until all are accepted (bounded).
    task automatic send(input int budget);
        int ia = 0;
        int ib = 0;
        int n = 0;
        logic fa;
        logic fb;
        @(posedge clk);
        #1;
        while ((ia < qa_num.size() || ib < qb_num.size()) && n < budget) begin
            a_valid = (ia < qa_num.size());
            b_valid = (ib < qb_num.size());
            if (a_valid) begin
                a_num = qa_num[ia];
                a_val = qa_val[ia];
            end
            if (b_valid) begin
                b_num = qb_num[ib];
                b_val = qb_val[ib];
            end
            #2;
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (fa) ia++;
            if (fb) ib++;
            n++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (ia < qa_num.size() || ib < qb_num.size()) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: accepted %0d/%0d, required %0d/%0d",
                     ia, ib, qa_num.size(), qb_num.size());
        end
        qa_num.delete();
        qa_val.delete();
        qb_num.delete();
        qb_val.delete();
    endtask

    // Monitor: every strobe must match the oldest expected write, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (we) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h/%h at cycle %0d, expected none",
                             wnum, wval, ec);
                end else begin
                    e = sb.pop_front();
                    if (wnum !== e.num || wval !== e.val || ec != e.cyc) begin
                        errors++;
                        $display("FAIL write: got %h/%h at cycle %0d, expected %h/%h at cycle %0d",
                                 wnum, wval, ec, e.num, e.val, e.cyc);
                    end else begin
                        $display("ok   write %h/%h at cycle %0d", wnum, wval, ec);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int f;

        // Reset state
        cycles(2);
        rst = 1'b0;
        check("reset_pending", pending, 0);
        check("reset_enable", we, 0);
        check("reset_number", wnum, 0);
        check("reset_value", wval, 0);
        check("reset_a_ready", a_ready, 1);
        check("reset_b_ready", b_ready, 1);

        // 1: single voice-op write, enable at t+2
        @(posedge clk);
        #1;
        a_valid = 1'b1;
        a_num   = 15'h4000;
        a_val   = 16'h1234;
        t = ec;
        expect_write(15'h4000, 16'h1234, t + 2);
        cycles(1);
        a_valid = 1'b0;
        check("t1_pending_t1", pending, 1);
        cycles(1);
        check("t1_pending_t2", pending, 0);
        cycles(2);

        // 2: contention, alternating A0,B0,A1,B1,A2,B2
        t = ec + 1;
        for (int i = 0; i < 3; i++) begin
            qa_num.push_back(15'(15'h4A00 + i));
            qa_val.push_back(16'(16'hA000 + i));
            qb_num.push_back(15'(15'h4B00 + i));
            qb_val.push_back(16'(16'hB000 + i));
        end
        for (int i = 0; i < 3; i++) begin
            expect_write(15'(15'h4A00 + i), 16'(16'hA000 + i), t + 2 + 2 * i);
            expect_write(15'(15'h4B00 + i), 16'(16'hB000 + i), t + 3 + 2 * i);
        end
        send(20);
        cycles(4);
        check("t2_pending", pending, 0);

        // 3: global head blocks voice-op until frame start
        qa_num.push_back(15'h0000);
        qa_val.push_back(16'h00FF);
        qa_num.push_back(15'h4100);
        qa_val.push_back(16'h0001);
        send(10);
        cycles(4);
        check("t3_pending_blocked", pending, 2);
        @(posedge clk);
        #1;
        frame = 1'b1;
        f = ec;
        expect_write(15'h0000, 16'h00FF, f + 1);
        expect_write(15'h4100, 16'h0001, f + 2);
        cycles(1);
        frame = 1'b0;
        cycles(3);
        check("t3_pending_drained", pending, 0);

        // 4: fill with globals, 9th stalls, one window issues 4
        for (int i = 0; i < 8; i++) begin
            qa_num.push_back(15'(15'h0010 + i));
            qa_val.push_back(16'(16'h4400 + i));
        end
        send(20);
        a_valid = 1'b1;
        a_num   = 15'h0018;
        a_val   = 16'h4408;
        #1;
        check("t4_pending_full", pending, 8);
        check("t4_a_ready_full", a_ready, 0);
        cycles(2);
        check("t4_a_ready_full_later", a_ready, 0);
        @(posedge clk);
        #1;
        frame = 1'b1;
        f = ec;
        for (int i = 0; i < 4; i++) begin
            expect_write(15'(15'h0010 + i), 16'(16'h4400 + i), f + 1 + i);
        end
        cycles(1);
        frame = 1'b0;
        check("t4_a_ready_after_pop", a_ready, 1);
        cycles(1);
        a_valid = 1'b0;
        cycles(6);
        check("t4_pending_after_window", pending, 5);

        // 5: reset with 5 queued discards everything
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("t5_pending", pending, 0);
        check("t5_enable", we, 0);
        check("t5_number", wnum, 0);
        check("t5_a_ready", a_ready, 1);
        for (int i = 0; i < 3; i++) begin
            frame = 1'b1;
            cycles(1);
            frame = 1'b0;
            cycles(4);
        end
        check("t5_pending_still_empty", pending, 0);

        // 6: second frame start mid-window extends it to 6 issues
        for (int i = 0; i < 8; i++) begin
            qa_num.push_back(15'(15'h0020 + i));
            qa_val.push_back(16'(16'h6600 + i));
        end
        send(20);
        @(posedge clk);
        #1;
        frame = 1'b1;
        f = ec;
        for (int i = 0; i < 6; i++) begin
            expect_write(15'(15'h0020 + i), 16'(16'h6600 + i), f + 1 + i);
        end
        cycles(1);
        frame = 1'b0;
        cycles(1);
        frame = 1'b1;
        cycles(1);
        frame = 1'b0;
        cycles(8);
        check("t6_pending_after_windows", pending, 2);
        @(posedge clk);
        #1;
        frame = 1'b1;
        f = ec;
        expect_write(15'h0026, 16'h6606, f + 1);
        expect_write(15'h0027, 16'h6607, f + 2);
        cycles(1);
        frame = 1'b0;
        cycles(5);
        check("t6_pending_final", pending, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
